// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// NOP constant and the default datapath width.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus. The fetch unit is the master;
// the memory (or its model) is the slave.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry valid/ready output register between memory and decode.
// Flush drops the entry; held data stays visible until overwritten.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_data_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q,  data_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  // Next-entry selection: flush wins over load, load wins over drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      pc_d    = load_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= XLEN'(NOP_INSTR);
      pc_q    <= {XLEN{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with taken-branch redirect.
// Responses for a redirected-away request are dropped via the discard flag.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  fetch_if.master         imem,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            discard_q, discard_d;

  logic            buf_valid_s;
  logic            buf_load_s;
  logic            req_s;
  logic            grant_s;
  logic [XLEN-1:0] target_s;

  assign target_s = branch_target_i & ALIGN_MASK;
  // Request only when the response will have somewhere to land.
  assign req_s    = (state_q == ST_REQ) && (!buf_valid_s || instr_ready_i);
  assign grant_s  = req_s && imem.gnt;

  assign imem.req  = req_s;
  assign imem.addr = pc_q;

  // Next-state, PC and discard bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    discard_d  = discard_q;
    buf_load_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (branch_i) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_REQ: begin
        if (grant_s) begin
          state_d   = ST_WAIT;
          pend_pc_d = pc_q;
          if (branch_i) begin
            pc_d      = target_s;
            discard_d = 1'b1;
          end else begin
            pc_d      = pc_q + PC_STEP;
            discard_d = 1'b0;
          end
        end else if (branch_i) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          state_d   = ST_REQ;
          discard_d = 1'b0;
          if (branch_i) begin
            pc_d = target_s;
          end else begin
            pc_d       = pc_q;
            buf_load_s = !discard_q;
          end
        end else if (branch_i) begin
          pc_d      = target_s;
          discard_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= {XLEN{1'b0}};
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_buffer #(
    .XLEN (XLEN)
  ) u_buffer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (branch_i),
    .load_i      (buf_load_s),
    .load_data_i (imem.rdata),
    .load_pc_i   (pend_pc_q),
    .ready_i     (instr_ready_i),
    .valid_o     (buf_valid_s),
    .data_o      (instr_o),
    .pc_o        (instr_pc_o)
  );

  assign instr_valid_o = buf_valid_s;

endmodule
